// File: rtl/delay_enable_pkg.sv
// Shared types for the multi-channel delay-pulse generator.
// Also provides the ns-to-cycles conversion used for the reset delay value.
package delay_enable_pkg;

   typedef enum logic [1:0] {
      ONESHOT   = 2'd0,
      RETRIGGER = 2'd1,
      PERIODIC  = 2'd2,
      RSVD      = 2'd3
   } delay_mode_t;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } channel_state_t;

   function automatic int unsigned ns_to_cycles(input int unsigned delay_ns,
                                                input int unsigned clk_period_ns);
      return delay_ns / clk_period_ns;
   endfunction

endpackage

// File: rtl/multi_delay_enable_if.sv
// Control/status bundle for multi_delay_enable: per-channel config, triggers and pulse outputs.
interface multi_delay_enable_if
   import delay_enable_pkg::*;
#(
   parameter int unsigned NR_OF_CHANNELS_P = 4,
   parameter int unsigned COUNTER_WIDTH_P  = 16
);

   logic        [NR_OF_CHANNELS_P-1:0][COUNTER_WIDTH_P-1:0] cr_delay_cycles;
   delay_mode_t [NR_OF_CHANNELS_P-1:0]                      cr_mode;
   logic        [NR_OF_CHANNELS_P-1:0]                      start;
   logic        [NR_OF_CHANNELS_P-1:0]                      stop;
   logic        [NR_OF_CHANNELS_P-1:0]                      delay_out;
   logic        [NR_OF_CHANNELS_P-1:0]                      busy;
   logic        [NR_OF_CHANNELS_P-1:0]                      trigger_lost;

   modport master (
      output cr_delay_cycles, cr_mode, start, stop,
      input  delay_out, busy, trigger_lost
   );

   modport slave (
      input  cr_delay_cycles, cr_mode, start, stop,
      output delay_out, busy, trigger_lost
   );

endinterface

// File: rtl/delay_enable_channel.sv
// One delay channel: IDLE/COUNT FSM with a down-counter and registered pulse/status outputs.
module delay_enable_channel
   import delay_enable_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH_P = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [COUNTER_WIDTH_P-1:0] i_delay,
   input  delay_mode_t                i_mode,
   input  logic                       i_start,
   input  logic                       i_stop,
   output logic                       o_delay_out,
   output logic                       o_busy,
   output logic                       o_trigger_lost
);

   localparam logic [COUNTER_WIDTH_P-1:0] ONE_LP = COUNTER_WIDTH_P'(1);

   channel_state_t               r_state;
   logic [COUNTER_WIDTH_P-1:0]   r_cnt;
   logic                         r_delay_out;
   logic                         r_busy;
   logic                         r_trigger_lost;

   logic [COUNTER_WIDTH_P-1:0]   w_load_val;
   logic                         w_expire;
   logic                         w_restartable;

   // D=0 loads the same count as D=1 so the pulse still comes one cycle after the start.
   always_comb begin
      w_load_val    = (i_delay == '0) ? '0 : (i_delay - ONE_LP);
      w_expire      = (r_state == COUNT) && (r_cnt == '0);
      w_restartable = (i_mode == RETRIGGER) || (i_mode == PERIODIC);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_delay_out    <= 1'b0;
         r_busy         <= 1'b0;
         r_trigger_lost <= 1'b0;
      end else begin
         r_delay_out    <= 1'b0;
         r_trigger_lost <= 1'b0;
         if (i_stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (i_start) begin
                     r_cnt   <= w_load_val;
                     r_state <= COUNT;
                     r_busy  <= 1'b1;
                  end
               end
               COUNT: begin
                  if (w_expire) begin
                     r_delay_out <= 1'b1;
                     if ((i_mode == PERIODIC) || i_start) begin
                        r_cnt <= w_load_val;
                     end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else if (i_start && w_restartable) begin
                     r_cnt <= w_load_val;
                  end else begin
                     r_trigger_lost <= i_start;
                     r_cnt          <= r_cnt - ONE_LP;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_delay_out    = r_delay_out;
   assign o_busy         = r_busy;
   assign o_trigger_lost = r_trigger_lost;

endmodule

// File: rtl/multi_delay_enable.sv
// Multi-channel programmable delay-pulse generator: NR_OF_CHANNELS_P independent channels,
// each emitting a one-cycle pulse a programmable number of cycles after its start.
module multi_delay_enable
   import delay_enable_pkg::*;
#(
   parameter int unsigned NR_OF_CHANNELS_P   = 4,
   parameter int unsigned COUNTER_WIDTH_P    = 16,
   parameter int unsigned CLK_PERIOD_P       = 10,
   parameter int unsigned DEFAULT_DELAY_NS_P = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   multi_delay_enable_if.slave  bus
);

   localparam int unsigned DEFAULT_DELAY_CYCLES_LP = ns_to_cycles(DEFAULT_DELAY_NS_P, CLK_PERIOD_P);

   if ((COUNTER_WIDTH_P < 32) && ((DEFAULT_DELAY_CYCLES_LP >> COUNTER_WIDTH_P) != 0)) begin : g_rst_delay_chk
      $error("multi_delay_enable: reset delay of %0d cycles does not fit %0d-bit counter",
             DEFAULT_DELAY_CYCLES_LP, COUNTER_WIDTH_P);
   end

   logic [NR_OF_CHANNELS_P-1:0] w_delay_out;
   logic [NR_OF_CHANNELS_P-1:0] w_busy;
   logic [NR_OF_CHANNELS_P-1:0] w_trigger_lost;

   for (genvar g = 0; g < NR_OF_CHANNELS_P; g++) begin : g_ch
      delay_enable_channel #(
         .COUNTER_WIDTH_P (COUNTER_WIDTH_P)
      ) u_channel (
         .i_clk          (clk),
         .i_rst          (rst),
         .i_delay        (bus.cr_delay_cycles[g]),
         .i_mode         (bus.cr_mode[g]),
         .i_start        (bus.start[g]),
         .i_stop         (bus.stop[g]),
         .o_delay_out    (w_delay_out[g]),
         .o_busy         (w_busy[g]),
         .o_trigger_lost (w_trigger_lost[g])
      );
   end

   assign bus.delay_out    = w_delay_out;
   assign bus.busy         = w_busy;
   assign bus.trigger_lost = w_trigger_lost;

endmodule

// File: tb/tb_multi_delay_enable.sv
// Self-checking bench for multi_delay_enable: directed scenarios plus random traffic
// compared against a deadline-based reference model.
module tb_multi_delay_enable;
   import delay_enable_pkg::*;

   localparam int unsigned N     = 4;
   localparam int unsigned W     = 16;
   localparam int unsigned CLK   = 10;
   localparam int unsigned DNS   = 1000;
   localparam int unsigned D_RST = DNS / CLK;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multi_delay_enable_if #(.NR_OF_CHANNELS_P(N), .COUNTER_WIDTH_P(W)) bus ();

   multi_delay_enable #(
      .NR_OF_CHANNELS_P   (N),
      .COUNTER_WIDTH_P    (W),
      .CLK_PERIOD_P       (CLK),
      .DEFAULT_DELAY_NS_P (DNS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;

   // Reference model: each channel is either idle or waiting for an absolute deadline edge.
   longint edge_n = 0;
   bit     m_busy [N];
   longint m_dl   [N];
   logic [N-1:0] exp_out, exp_busy, exp_lost;

   task automatic advance();
      @(posedge clk);
      edge_n++;
      exp_out  = '0;
      exp_lost = '0;
      for (int ch = 0; ch < N; ch++) begin
         longint d;
         d = (bus.cr_delay_cycles[ch] == 0) ? 1 : longint'(bus.cr_delay_cycles[ch]);
         if (rst) begin
            m_busy[ch] = 0;
         end else if (bus.stop[ch]) begin
            m_busy[ch] = 0;
         end else if (m_busy[ch] && edge_n == m_dl[ch]) begin
            exp_out[ch] = 1'b1;
            if (bus.cr_mode[ch] == PERIODIC || bus.start[ch]) m_dl[ch] = edge_n + d;
            else m_busy[ch] = 0;
         end else if (m_busy[ch] && bus.start[ch]) begin
            if (bus.cr_mode[ch] == RETRIGGER || bus.cr_mode[ch] == PERIODIC) m_dl[ch] = edge_n + d;
            else exp_lost[ch] = 1'b1;
         end else if (!m_busy[ch] && bus.start[ch]) begin
            m_busy[ch] = 1;
            m_dl[ch]   = edge_n + d;
         end
         exp_busy[ch] = m_busy[ch];
      end
      #1;
   endtask

   task automatic do_reset();
      bus.start = '0;
      bus.stop  = '0;
      rst = 1'b1;
      advance();
      advance();
      rst = 1'b0;
   endtask

   task automatic setup_all(input delay_mode_t md, input int d);
      for (int ch = 0; ch < N; ch++) begin
         bus.cr_mode[ch]         = md;
         bus.cr_delay_cycles[ch] = W'(d);
      end
   endtask

   task automatic test_reset();
      bus.cr_delay_cycles = '1;
      setup_all(RETRIGGER, 3);
      bus.start = '1;
      bus.stop  = '0;
      rst = 1'b1;
      advance();
      advance();
      if ({bus.delay_out, bus.busy, bus.trigger_lost} !== '0)
         $display("FAIL reset_state got=%h exp=0", {bus.delay_out, bus.busy, bus.trigger_lost});
      else passes++;
      checks++;
      rst = 1'b0;
      bus.start = '0;
      advance();
      if ({bus.delay_out, bus.busy, bus.trigger_lost} !== {exp_out, exp_busy, exp_lost})
         $display("FAIL reset_model got=%h exp=%h", {bus.delay_out, bus.busy, bus.trigger_lost}, {exp_out, exp_busy, exp_lost});
      else passes++;
      checks++;
   endtask

   task automatic test_oneshot_latency();
      int dl [3] = '{5, 0, 1};
      for (int i = 0; i < 3; i++) begin
         longint base;
         int pulse_at = -1;
         do_reset();
         setup_all(ONESHOT, dl[i]);
         bus.start[0] = 1'b1;
         advance();
         base = edge_n;
         bus.start[0] = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            advance();
            if (bus.delay_out[0] && pulse_at < 0) pulse_at = int'(edge_n - base);
            if ({bus.delay_out, bus.busy, bus.trigger_lost} !== {exp_out, exp_busy, exp_lost})
               $display("FAIL latency_model d=%0d k=%0d got=%h exp=%h", dl[i], k, {bus.delay_out, bus.busy, bus.trigger_lost}, {exp_out, exp_busy, exp_lost});
            else passes++;
            checks++;
         end
         if (pulse_at !== ((dl[i] == 0) ? 1 : dl[i]))
            $display("FAIL latency_edge d=%0d got=%0d exp=%0d", dl[i], pulse_at, (dl[i] == 0) ? 1 : dl[i]);
         else passes++;
         checks++;
      end
   endtask

   task automatic test_oneshot_lost();
      longint base;
      int pulses [$];
      int lost_at = -1;
      do_reset();
      setup_all(ONESHOT, 8);
      bus.start[0] = 1'b1;
      advance();
      base = edge_n;
      bus.start[0] = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         bus.start[0] = (k == 3 || k == 8);
         advance();
         if (bus.delay_out[0]) pulses.push_back(int'(edge_n - base));
         if (bus.trigger_lost[0] && lost_at < 0) lost_at = int'(edge_n - base);
         if ({bus.delay_out, bus.busy, bus.trigger_lost} !== {exp_out, exp_busy, exp_lost})
            $display("FAIL oneshot_model k=%0d got=%h exp=%h", k, {bus.delay_out, bus.busy, bus.trigger_lost}, {exp_out, exp_busy, exp_lost});
         else passes++;
         checks++;
      end
      bus.start[0] = 1'b0;
      if (lost_at !== 3) $display("FAIL oneshot_lost_edge got=%0d exp=3", lost_at);
      else passes++;
      checks++;
      if (pulses.size() != 2 || pulses[0] != 8 || pulses[1] != 16)
         $display("FAIL oneshot_pulses got=%p exp=8,16", pulses);
      else passes++;
      checks++;
   endtask

   task automatic test_retrigger();
      longint base;
      int pulses [$];
      do_reset();
      setup_all(RETRIGGER, 6);
      bus.start[0] = 1'b1;
      advance();
      base = edge_n;
      for (int k = 1; k <= 18; k++) begin
         bus.start[0] = (k == 4 || k == 8);
         advance();
         if (bus.delay_out[0]) pulses.push_back(int'(edge_n - base));
         if ({bus.delay_out, bus.busy, bus.trigger_lost} !== {exp_out, exp_busy, exp_lost})
            $display("FAIL retrigger_model k=%0d got=%h exp=%h", k, {bus.delay_out, bus.busy, bus.trigger_lost}, {exp_out, exp_busy, exp_lost});
         else passes++;
         checks++;
      end
      bus.start[0] = 1'b0;
      if (pulses.size() != 1 || pulses[0] != 14)
         $display("FAIL retrigger_pulses got=%p exp=14", pulses);
      else passes++;
      checks++;
   endtask

   task automatic test_periodic();
      longint base;
      int pulses [$];
      do_reset();
      setup_all(PERIODIC, 3);
      bus.start[0] = 1'b1;
      advance();
      base = edge_n;
      bus.start[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 4) bus.cr_delay_cycles[0] = W'(5);
         bus.stop[0] = (k == 16);
         advance();
         if (bus.delay_out[0]) pulses.push_back(int'(edge_n - base));
         if ({bus.delay_out, bus.busy, bus.trigger_lost} !== {exp_out, exp_busy, exp_lost})
            $display("FAIL periodic_model k=%0d got=%h exp=%h", k, {bus.delay_out, bus.busy, bus.trigger_lost}, {exp_out, exp_busy, exp_lost});
         else passes++;
         checks++;
      end
      bus.stop[0] = 1'b0;
      if (pulses.size() != 3 || pulses[0] != 3 || pulses[1] != 6 || pulses[2] != 11)
         $display("FAIL periodic_pulses got=%p exp=3,6,11", pulses);
      else passes++;
      checks++;
      if (bus.busy[0] !== 1'b0) $display("FAIL periodic_stop_busy got=%b exp=0", bus.busy[0]);
      else passes++;
      checks++;
   endtask

   task automatic test_multi_channel();
      longint base;
      int first [N];
      int exp_first [N] = '{2, -1, 3, 7};
      int dl [N] = '{2, 3, 3, 7};
      do_reset();
      for (int ch = 0; ch < N; ch++) begin
         bus.cr_mode[ch]         = ONESHOT;
         bus.cr_delay_cycles[ch] = W'(dl[ch]);
         first[ch] = -1;
      end
      bus.start = '1;
      advance();
      base = edge_n;
      bus.start = '0;
      for (int k = 1; k <= 10; k++) begin
         bus.stop[1] = (k == 3);
         advance();
         for (int ch = 0; ch < N; ch++)
            if (bus.delay_out[ch] && first[ch] < 0) first[ch] = int'(edge_n - base);
         if ({bus.delay_out, bus.busy, bus.trigger_lost} !== {exp_out, exp_busy, exp_lost})
            $display("FAIL multi_model k=%0d got=%h exp=%h", k, {bus.delay_out, bus.busy, bus.trigger_lost}, {exp_out, exp_busy, exp_lost});
         else passes++;
         checks++;
      end
      bus.stop = '0;
      for (int ch = 0; ch < N; ch++) begin
         if (first[ch] !== exp_first[ch])
            $display("FAIL multi_pulse ch=%0d got=%0d exp=%0d", ch, first[ch], exp_first[ch]);
         else passes++;
         checks++;
      end
   endtask

   task automatic test_reset_midcount();
      longint base;
      int pulse_at = -1;
      int n_pulses = 0;
      do_reset();
      setup_all(ONESHOT, 10);
      bus.start = '1;
      advance();
      bus.start = '0;
      advance();
      rst = 1'b1;
      advance();
      rst = 1'b0;
      if ({bus.delay_out, bus.busy, bus.trigger_lost} !== '0)
         $display("FAIL midreset_state got=%h exp=0", {bus.delay_out, bus.busy, bus.trigger_lost});
      else passes++;
      checks++;
      for (int k = 0; k < 12; k++) begin
         advance();
         if (bus.delay_out != '0) n_pulses++;
      end
      if (n_pulses !== 0) $display("FAIL midreset_no_pulse got=%0d exp=0", n_pulses);
      else passes++;
      checks++;
      setup_all(ONESHOT, D_RST);
      bus.start[0] = 1'b1;
      advance();
      base = edge_n;
      bus.start[0] = 1'b0;
      for (int k = 1; k <= int'(D_RST) + 2; k++) begin
         advance();
         if (bus.delay_out[0] && pulse_at < 0) pulse_at = int'(edge_n - base);
         if ({bus.delay_out, bus.busy, bus.trigger_lost} !== {exp_out, exp_busy, exp_lost})
            $display("FAIL drst_model k=%0d got=%h exp=%h", k, {bus.delay_out, bus.busy, bus.trigger_lost}, {exp_out, exp_busy, exp_lost});
         else passes++;
         checks++;
      end
      if (pulse_at !== int'(D_RST)) $display("FAIL drst_edge got=%0d exp=%0d", pulse_at, D_RST);
      else passes++;
      checks++;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         for (int ch = 0; ch < N; ch++) begin
            if ($urandom_range(0, 15) == 0) bus.cr_mode[ch] = delay_mode_t'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) bus.cr_delay_cycles[ch] = W'($urandom_range(0, 12));
            bus.start[ch] = ($urandom_range(0, 4) == 0);
            bus.stop[ch]  = ($urandom_range(0, 19) == 0);
         end
         rst = ($urandom_range(0, 299) == 0);
         advance();
         if ({bus.delay_out, bus.busy, bus.trigger_lost} !== {exp_out, exp_busy, exp_lost})
            $display("FAIL random_model k=%0d got=%h exp=%h", k, {bus.delay_out, bus.busy, bus.trigger_lost}, {exp_out, exp_busy, exp_lost});
         else passes++;
         checks++;
      end
      rst = 1'b0;
      bus.start = '0;
      bus.stop  = '0;
   endtask

   initial begin
      rst = 1'b1;
      bus.start = '0;
      bus.stop  = '0;
      bus.cr_delay_cycles = '0;
      for (int ch = 0; ch < N; ch++) begin
         bus.cr_mode[ch] = ONESHOT;
         m_busy[ch] = 0;
         m_dl[ch]   = 0;
      end
      exp_out = '0; exp_busy = '0; exp_lost = '0;
      #2;
      test_reset();
      test_oneshot_latency();
      test_oneshot_lost();
      test_retrigger();
      test_periodic();
      test_multi_channel();
      test_reset_midcount();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
